// File: rtl/dcache_port_responder.sv
// D$ request-port responder: 64-bit word SRAM model behind one D$ port.
// Reads use the two-phase protocol: the index is granted first, the tag
// follows in a later cycle, and data returns one cycle after the tag.
// Writes complete in the cycle they are granted. stall_i withholds the
// grant so requester stall paths can be exercised.

package dcache_port_pkg;
    localparam int unsigned DC_INDEX_W = 12;
    localparam int unsigned DC_TAG_W   = 44;

    typedef struct packed {
        logic [DC_INDEX_W-1:0] address_index;
        logic [DC_TAG_W-1:0]   address_tag;
        logic [63:0]           data_wdata;
        logic                  data_req;
        logic                  data_we;
        logic [7:0]            data_be;
        logic [1:0]            data_size;
        logic                  kill_req;
        logic                  tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;
endpackage

module dcache_port_responder
    import dcache_port_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o,
    output logic          busy_o
);

    localparam int unsigned WORD_AW = $clog2(MEM_WORDS);
    localparam int unsigned PADDR_W = DC_TAG_W + DC_INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_TAG = 2'd1,
        RESP     = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DC_INDEX_W-1:0] idx_q, idx_d;
    logic [63:0]           rdata_q;
    logic [63:0]           mem_q [MEM_WORDS];

    // Physical address views: writes use the address presented now, reads
    // combine the tag presented now with the index latched at grant.
    logic [PADDR_W-1:0]    wr_paddr;
    logic [PADDR_W-1:0]    rd_paddr;
    logic [WORD_AW-1:0]    wr_word;
    logic [WORD_AW-1:0]    rd_word;

    logic                  gnt;
    logic                  mem_we;
    logic                  rd_en;

    assign wr_paddr = {req_port_i.address_tag, req_port_i.address_index};
    assign rd_paddr = {req_port_i.address_tag, idx_q};

    // Byte offset bits select nothing; address bits above the array depth
    // are dropped so the store aliases with period MEM_WORDS.
    assign wr_word = wr_paddr[3 +: WORD_AW];
    assign rd_word = rd_paddr[3 +: WORD_AW];

    // State, latched read index
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, grant, write strobe and tag-phase read enable
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gnt     = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;

        if (rst_i) begin
            // Nothing is granted while reset is high; any read is dropped.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    // RESP accepts a new request in the same cycle it
                    // returns data, so both states share this arm.
                    state_d = IDLE;
                    gnt     = req_port_i.data_req & ~stall_i;
                    if (gnt) begin
                        if (req_port_i.data_we) begin
                            mem_we = 1'b1;
                        end else begin
                            idx_d   = req_port_i.address_index;
                            state_d = WAIT_TAG;
                        end
                    end
                end
                WAIT_TAG: begin
                    // Kill beats a tag presented in the same cycle.
                    if (req_port_i.kill_req) begin
                        state_d = IDLE;
                    end else if (req_port_i.tag_valid) begin
                        rd_en   = 1'b1;
                        state_d = RESP;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte-masked write into the backing store (contents survive reset)
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (req_port_i.data_be[b]) begin
                    mem_q[wr_word][8*b +: 8] <= req_port_i.data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register; loaded in the tag cycle, held until the next read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[rd_word];
        end
    end

    assign req_port_o.data_gnt    = gnt;
    assign req_port_o.data_rvalid = (state_q == RESP) & ~rst_i;
    assign req_port_o.data_rdata  = rdata_q;
    assign busy_o                 = (state_q != IDLE) & ~rst_i;

    // Address bits below the word and above the array depth, plus the
    // size field, have no effect on this model.
    logic unused_sigs;
    assign unused_sigs = ^{req_port_i.data_size,
                           wr_paddr[2:0], wr_paddr[PADDR_W-1:3+WORD_AW],
                           rd_paddr[2:0], rd_paddr[PADDR_W-1:3+WORD_AW]};

endmodule

// File: tb/tb_dcache_port_responder.sv
// Bench for dcache_port_responder: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level model (word map, one pending read, one pending reply).
module tb_dcache_port_responder;
    import dcache_port_pkg::*;

    localparam int MW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    dcache_req_i_t rq;
    dcache_req_o_t rs;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dcache_port_responder #(.MEM_WORDS(MW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .stall_i   (stall),
        .req_port_i(rq),
        .req_port_o(rs),
        .busy_o    (busy)
    );

    // ---------------- reference model ----------------
    logic [63:0] mmem [int];
    bit          m_live     = 0;
    bit          m_inflight = 0;
    logic [11:0] m_idx      = '0;
    bit          m_rsp      = 0;
    logic [63:0] m_rdata    = '0;
    bit          m_known    = 0;
    logic [63:0] rv_q [$];
    int          rv_cyc [$];

    function automatic int word_of(input logic [43:0] tag, input logic [11:0] idx);
        logic [55:0] p;
        p = {tag, idx};
        return int'((p >> 3) % MW);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs against the model, then advance the model with
    // this cycle's inputs (stable from posedge+1 until the next posedge).
    always @(negedge clk) begin
        bit          eg;
        int          w;
        logic [63:0] nv;
        eg = rq.data_req && !stall && !m_inflight && !rst;
        if (m_live) begin
            chk("gnt",    rs.data_gnt,    eg);
            chk("rvalid", rs.data_rvalid, m_rsp && !rst);
            chk("busy",   busy,           (m_inflight || m_rsp) && !rst);
            if (m_known) chk("rdata", rs.data_rdata, m_rdata);
            if (rs.data_rvalid === 1'b1) begin
                rv_q.push_back(rs.data_rdata);
                rv_cyc.push_back(cyc);
            end
        end
        if (rst) begin
            m_live = 1; m_inflight = 0; m_rsp = 0; m_rdata = '0; m_known = 1;
        end else if (m_live) begin
            m_rsp = 0;
            if (m_inflight) begin
                if (rq.kill_req) begin
                    m_inflight = 0;
                end else if (rq.tag_valid) begin
                    w = word_of(rq.address_tag, m_idx);
                    m_inflight = 0;
                    m_rsp = 1;
                    m_known = mmem.exists(w);
                    if (m_known) m_rdata = mmem[w];
                end
            end else if (eg) begin
                if (rq.data_we) begin
                    w  = word_of(rq.address_tag, rq.address_index);
                    nv = mmem.exists(w) ? mmem[w] : 64'h0;
                    for (int b = 0; b < 8; b++)
                        if (rq.data_be[b]) nv[8*b +: 8] = rq.data_wdata[8*b +: 8];
                    mmem[w] = nv;
                end else begin
                    m_inflight = 1;
                    m_idx = rq.address_index;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [11:0] idx, input logic [43:0] tag,
                            input logic [63:0] d, input logic [7:0] be,
                            input bit rstall, output int waits);
        bit g;
        g = 0; waits = 0;
        rq.data_req = 1; rq.data_we = 1; rq.address_index = idx;
        rq.address_tag = tag; rq.data_wdata = d; rq.data_be = be;
        rq.data_size = 2'($urandom);
        for (int i = 0; i < 50 && !g; i++) begin
            stall = rstall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            g = rs.data_gnt;
            if (!g) waits++;
            tick();
        end
        if (!g) chk("write_grant_timeout", 64'(g), 64'd1);
        rq.data_req = 0; rq.data_we = 0; stall = 0;
    endtask

    // mode 0: tag phase, 1: kill (with tag_valid), 2: reset during WAIT_TAG
    task automatic do_read(input logic [11:0] idx, input logic [43:0] tag,
                           input int delay, input int mode, input bit rstall,
                           output int gcyc);
        bit g;
        g = 0; gcyc = -1;
        rq.data_req = 1; rq.data_we = 0; rq.address_index = idx;
        rq.address_tag = {$urandom, $urandom}; rq.tag_valid = 0; rq.kill_req = 0;
        for (int i = 0; i < 50 && !g; i++) begin
            stall = rstall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            g = rs.data_gnt;
            if (g) gcyc = cyc;
            tick();
        end
        stall = 0;
        if (!g) begin
            chk("read_grant_timeout", 64'(g), 64'd1);
            rq.data_req = 0;
            return;
        end
        // Scramble the index: the DUT must use the one latched at grant.
        rq.address_index = 12'($urandom);
        for (int i = 0; i < delay; i++) begin
            stall = 1'($urandom);
            tick();
        end
        stall = 0;
        rq.address_tag = tag;
        case (mode)
            0: rq.tag_valid = 1;
            1: begin rq.tag_valid = 1; rq.kill_req = 1; end
            default: rst = 1;
        endcase
        rq.data_req = 0;
        tick();
        rq.tag_valid = 0; rq.kill_req = 0; rst = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w, g, g2;
        rq = '0; stall = 0; rst = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("reset_gnt",    64'(rs.data_gnt),    64'd0);
        chk("reset_rvalid", 64'(rs.data_rvalid), 64'd0);
        chk("reset_rdata",  rs.data_rdata,       64'd0);
        chk("reset_busy",   64'(busy),           64'd0);
        tick();

        // 1: full write then read, zero-wait grant, gnt->rvalid = 2
        do_write(12'h010, 44'h0, 64'h1122334455667788, 8'hFF, 0, w);
        chk("t1_write_wait", 64'(w), 64'd0);
        chk("t1_model_word", mmem[2], 64'h1122334455667788);
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h010, 44'h0, 0, 0, 0, g);
        tick();
        chk("t1_rvalid_count", 64'(rv_q.size()), 64'd1);
        if (rv_q.size() == 1) begin
            chk("t1_rdata",   rv_q[0], 64'h1122334455667788);
            chk("t1_latency", 64'(rv_cyc[0] - g), 64'd2);
        end

        // 2: partial write over low bytes
        do_write(12'h010, 44'h0, 64'hAAAAAAAABBBBBBBB, 8'h0F, 0, w);
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h010, 44'h0, 0, 0, 0, g);
        tick();
        chk("t2_rvalid_count", 64'(rv_q.size()), 64'd1);
        if (rv_q.size() == 1) chk("t2_rdata", rv_q[0], 64'h11223344BBBBBBBB);

        // 3: kill with tag_valid in the same cycle
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h010, 44'h0, 1, 1, 0, g);
        @(negedge clk);
        chk("t3_busy_after_kill", 64'(busy), 64'd0);
        tick(); tick();
        chk("t3_no_rvalid", 64'(rv_q.size()), 64'd0);

        // 4: three stalled cycles, grant on the fourth
        rq.data_req = 1; rq.data_we = 1; rq.address_index = 12'h018;
        rq.address_tag = '0; rq.data_wdata = 64'h5555_6666_7777_8888; rq.data_be = 8'hFF;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stalled_gnt", 64'(rs.data_gnt), 64'd0);
            tick();
        end
        stall = 0;
        @(negedge clk);
        chk("t4_gnt_after_stall", 64'(rs.data_gnt), 64'd1);
        tick();
        rq.data_req = 0; rq.data_we = 0;
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h018, 44'h0, 0, 0, 0, g);
        tick();
        if (rv_q.size() == 1) chk("t4_rdata", rv_q[0], 64'h5555666677778888);
        else chk("t4_rvalid_count", 64'(rv_q.size()), 64'd1);

        // 6: reset during WAIT_TAG, then old data, then aliasing
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h010, 44'h0, 1, 2, 0, g);
        @(negedge clk);
        chk("t6_rdata_after_rst", rs.data_rdata, 64'd0);
        chk("t6_busy_after_rst",  64'(busy),     64'd0);
        tick(); tick();
        chk("t6_no_rvalid", 64'(rv_q.size()), 64'd0);
        do_read(12'h010, 44'h0, 0, 0, 0, g);
        tick();
        if (rv_q.size() == 1) chk("t6_old_data", rv_q[0], 64'h11223344BBBBBBBB);
        else chk("t6_rvalid_count", 64'(rv_q.size()), 64'd1);
        chk("t6_model_alias_word", 64'(word_of(44'h2, 12'h028)), 64'd5);
        do_write(12'h028, 44'h2, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, w);
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h028, 44'h0, 0, 0, 0, g);
        tick();
        if (rv_q.size() == 1) chk("t6_alias_rdata", rv_q[0], 64'hDEADBEEFCAFEF00D);
        else chk("t6_alias_count", 64'(rv_q.size()), 64'd1);

        // 5: back-to-back reads of words 0,1,2 with 2-cycle tag delay
        do_write(12'h000, 44'h0, 64'hA, 8'hFF, 0, w);
        do_write(12'h008, 44'h0, 64'hB, 8'hFF, 0, w);
        do_write(12'h010, 44'h0, 64'hC, 8'hFF, 0, w);
        rv_q.delete(); rv_cyc.delete();
        do_read(12'h000, 44'h0, 2, 0, 0, g);
        do_read(12'h008, 44'h0, 2, 0, 0, g2);
        do_read(12'h010, 44'h0, 2, 0, 0, g);
        tick(); tick();
        chk("t5_rvalid_count", 64'(rv_q.size()), 64'd3);
        if (rv_q.size() == 3) begin
            chk("t5_rdata0", rv_q[0], 64'hA);
            chk("t5_rdata1", rv_q[1], 64'hB);
            chk("t5_rdata2", rv_q[2], 64'hC);
            chk("t5_spacing", 64'(rv_cyc[1] - rv_cyc[0]), 64'd4);
        end

        // Randomized phase over 16 words, random aliasing tags
        for (int i = 0; i < 16; i++)
            do_write(12'(i << 3), {$urandom, $urandom} & ~44'h1, {$urandom, $urandom}, 8'hFF, 0, w);
        for (int n = 0; n < 300; n++) begin
            int          op, wd, md;
            logic [11:0] ix;
            logic [43:0] tg;
            op = $urandom_range(0, 2);
            wd = $urandom_range(0, 15);
            ix = 12'((wd << 3) | $urandom_range(0, 7));
            tg = {$urandom, $urandom} & ~44'h1;
            if (op == 0) begin
                do_write(ix, tg, {$urandom, $urandom}, 8'($urandom), 1, w);
            end else begin
                md = $urandom_range(0, 15);
                md = (md == 0) ? 2 : (md < 3) ? 1 : 0;
                do_read(ix, tg, $urandom_range(0, 3), md, 1, g);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
